regfile_operand_fetch: RTL and testbench

Read-side controller for the 4×10-bit register file. It accepts operand-fetch requests from the decode stage and drives the file's read address/enable lines. It captures the operands returned on the shared tri-state Q0/Q1 buses and presents them downstream with a valid/ready handshake. It also forwards single-cycle write-back requests onto the file's write port and bypasses same-cycle write data to fetched operands.

---
 rtl/regfile_operand_fetch.sv | 136 +++++++++++++
 tb/tb_regfile_operand_fetch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_operand_fetch.sv
`timescale 1ns/1ps
// Read-side controller for a small register file: fetches up to two operands,
// bypasses same-cycle write-back data and presents them with valid/ready.
module regfile_operand_fetch #(
   parameter int WIDTH = 10,
   parameter int AW    = 2
) (
   input  logic             Clkb,
   input  logic             Rstb,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [AW-1:0]    req_rs0,
   input  logic [AW-1:0]    req_rs1,
   input  logic             req_use1,
   output logic             op_valid,
   input  logic             op_ready,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   input  logic             wb_valid,
   output logic             wb_ready,
   input  logic [AW-1:0]    wb_addr,
   input  logic [WIDTH-1:0] wb_data,
   output logic [WIDTH-1:0] D,
   output logic [AW-1:0]    WRA,
   output logic             ENW,
   output logic [AW-1:0]    RDA0,
   output logic             ENR0,
   output logic [AW-1:0]    RDA1,
   output logic             ENR1,
   input  logic [WIDTH-1:0] Q0,
   input  logic [WIDTH-1:0] Q1
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state_q;
   logic [AW-1:0]    rs0_q;
   logic [AW-1:0]    rs1_q;
   logic             use1_q;
   logic             op_valid_q;
   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic [WIDTH-1:0] op_a_d;
   logic [WIDTH-1:0] op_b_d;
   logic             fetch_s;
   logic             accept_s;

   // Write port is a straight pass-through, gated only by reset.
   assign wb_ready = Rstb;
   assign ENW      = wb_valid & Rstb;
   assign D        = wb_data;
   assign WRA      = wb_addr;

   assign fetch_s  = Rstb & (state_q == FETCH);
   assign ENR0     = fetch_s;
   assign ENR1     = fetch_s & use1_q;
   assign RDA0     = fetch_s ? rs0_q : {AW{1'b0}};
   assign RDA1     = fetch_s ? rs1_q : {AW{1'b0}};

   assign req_ready = Rstb & ((state_q == IDLE) | ((state_q == HOLD) & op_ready));
   assign accept_s  = req_valid & req_ready;

   assign op_valid = op_valid_q;
   assign op_a     = op_a_q;
   assign op_b     = op_b_q;

   // Operand selection at the fetch edge: a write landing this cycle wins over the stale bus value.
   always_comb begin
      op_a_d = Q0;
      op_b_d = {WIDTH{1'b0}};
      if (ENW && (WRA == rs0_q)) begin
         op_a_d = wb_data;
      end else begin
         op_a_d = Q0;
      end
      if (!use1_q) begin
         op_b_d = {WIDTH{1'b0}};
      end else if (ENW && (WRA == rs1_q)) begin
         op_b_d = wb_data;
      end else begin
         op_b_d = Q1;
      end
   end

   // Request/fetch/hold sequencer with registered operand outputs.
   always_ff @(posedge Clkb) begin
      if (!Rstb) begin
         state_q    <= IDLE;
         rs0_q      <= {AW{1'b0}};
         rs1_q      <= {AW{1'b0}};
         use1_q     <= 1'b0;
         op_valid_q <= 1'b0;
         op_a_q     <= {WIDTH{1'b0}};
         op_b_q     <= {WIDTH{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  rs0_q   <= req_rs0;
                  rs1_q   <= req_rs1;
                  use1_q  <= req_use1;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               op_a_q     <= op_a_d;
               op_b_q     <= op_b_d;
               op_valid_q <= 1'b1;
               state_q    <= HOLD;
            end
            HOLD: begin
               if (op_ready) begin
                  op_valid_q <= 1'b0;
                  if (accept_s) begin
                     rs0_q   <= req_rs0;
                     rs1_q   <= req_rs1;
                     use1_q  <= req_use1;
                     state_q <= FETCH;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               op_valid_q <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
`timescale 1ns/1ps
// Bench for regfile_operand_fetch: a directed vector table, hand-written
// backpressure/reset sequences and a randomized run against a transaction model.
module tb_regfile_operand_fetch;
   localparam int WIDTH = 10;
   localparam int AW    = 2;

   logic             Clkb = 1'b0;
   logic             Rstb;
   logic             req_valid, req_use1, op_ready, wb_valid;
   logic [AW-1:0]    req_rs0, req_rs1, wb_addr;
   logic [WIDTH-1:0] wb_data;
   logic             req_ready, op_valid, wb_ready, ENW, ENR0, ENR1;
   logic [WIDTH-1:0] op_a, op_b, D;
   logic [AW-1:0]    WRA, RDA0, RDA1;
   wire  [WIDTH-1:0] Q0, Q1;

   logic [WIDTH-1:0] rf  [4];
   logic [WIDTH-1:0] mdl [4];
   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0] rs0;
      logic [1:0] rs1;
      logic       use1;
      logic       wb_en;
      logic [1:0] wb_a;
      logic [9:0] wb_d;
      logic [9:0] exp_a;
      logic [9:0] exp_b;
   } vec_t;

   vec_t vecs [7];

   regfile_operand_fetch #(.WIDTH(WIDTH), .AW(AW)) dut (
      .Clkb(Clkb), .Rstb(Rstb),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rs0(req_rs0), .req_rs1(req_rs1), .req_use1(req_use1),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .D(D), .WRA(WRA), .ENW(ENW),
      .RDA0(RDA0), .ENR0(ENR0), .RDA1(RDA1), .ENR1(ENR1),
      .Q0(Q0), .Q1(Q1)
   );

   always #5 Clkb = ~Clkb;

   // Register file hanging off the DUT pins; reference copy follows the request inputs directly.
   always @(posedge Clkb) if (ENW) rf[WRA] <= D;
   always @(posedge Clkb) if (wb_valid && Rstb) mdl[wb_addr] <= wb_data;
   assign Q0 = ENR0 ? rf[RDA0] : {WIDTH{1'bz}};
   assign Q1 = ENR1 ? rf[RDA1] : {WIDTH{1'bz}};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clkb);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [9:0] d);
      wb_valid = 1'b1; wb_addr = a; wb_data = d;
      step();
      wb_valid = 1'b0;
   endtask

   task automatic do_fetch(input vec_t v);
      req_valid = 1'b1; req_rs0 = v.rs0; req_rs1 = v.rs1; req_use1 = v.use1; op_ready = 1'b0;
      #1;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0; req_rs0 = ~v.rs0; req_rs1 = ~v.rs1; req_use1 = ~v.use1;
      wb_valid = v.wb_en; wb_addr = v.wb_a; wb_data = v.wb_d;
      #1;
      chk("fetch_enr0", 32'(ENR0), 32'd1);
      chk("fetch_enr1", 32'(ENR1), 32'(v.use1));
      chk("fetch_rda0", 32'(RDA0), 32'(v.rs0));
      chk("fetch_rda1", 32'(RDA1), 32'(v.rs1));
      chk("fetch_op_valid", 32'(op_valid), 32'd0);
      chk("fetch_req_ready", 32'(req_ready), 32'd0);
      step();
      wb_valid = 1'b0;
      chk("hold_op_valid", 32'(op_valid), 32'd1);
      chk("hold_op_a", 32'(op_a), 32'(v.exp_a));
      chk("hold_op_b", 32'(op_b), 32'(v.exp_b));
      chk("hold_enr0", 32'(ENR0), 32'd0);
      chk("hold_enr1", 32'(ENR1), 32'd0);
      chk("hold_rda0", 32'(RDA0), 32'd0);
      op_ready = 1'b1;
      step();
      op_ready = 1'b0;
      chk("release_op_valid", 32'(op_valid), 32'd0);
   endtask

   initial begin
      logic       pend, have, pu, exp_rdy;
      logic [1:0] p0, p1;
      logic [9:0] ea, eb;

      vecs[0] = '{2'd1, 2'd2, 1'b1, 1'b0, 2'd0, 10'h000, 10'h155, 10'h2AA};
      vecs[1] = '{2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 10'h000, 10'h155, 10'h000};
      vecs[2] = '{2'd3, 2'd3, 1'b1, 1'b1, 2'd3, 10'h3FF, 10'h3FF, 10'h3FF};
      vecs[3] = '{2'd3, 2'd0, 1'b1, 1'b0, 2'd0, 10'h000, 10'h3FF, 10'h0AB};
      vecs[4] = '{2'd2, 2'd1, 1'b1, 1'b1, 2'd1, 10'h0F0, 10'h2AA, 10'h0F0};
      vecs[5] = '{2'd0, 2'd1, 1'b0, 1'b1, 2'd1, 10'h111, 10'h0AB, 10'h000};
      vecs[6] = '{2'd1, 2'd1, 1'b1, 1'b1, 2'd2, 10'h222, 10'h111, 10'h111};

      Rstb = 1'b0; req_valid = 1'b1; req_rs0 = 2'd1; req_rs1 = 2'd2; req_use1 = 1'b1;
      op_ready = 1'b0; wb_valid = 1'b1; wb_addr = 2'd0; wb_data = 10'h3FF;
      step();
      step();
      chk("rst_op_valid", 32'(op_valid), 32'd0);
      chk("rst_op_a", 32'(op_a), 32'd0);
      chk("rst_op_b", 32'(op_b), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_wb_ready", 32'(wb_ready), 32'd0);
      chk("rst_enw", 32'(ENW), 32'd0);
      chk("rst_enr0", 32'(ENR0), 32'd0);
      chk("rst_rda1", 32'(RDA1), 32'd0);
      Rstb = 1'b1; req_valid = 1'b0; wb_valid = 1'b0;
      #1;
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);
      chk("post_rst_wb_ready", 32'(wb_ready), 32'd1);

      wr(2'd0, 10'h0AB);
      wr(2'd1, 10'h155);
      wr(2'd2, 10'h2AA);
      wr(2'd3, 10'h001);

      for (int i = 0; i < 7; i++) do_fetch(vecs[i]);

      // Backpressure: file now r0=0AB r1=111 r2=222 r3=3FF.
      req_valid = 1'b1; req_rs0 = 2'd1; req_rs1 = 2'd2; req_use1 = 1'b1; op_ready = 1'b0;
      step();
      req_rs0 = 2'd0; req_rs1 = 2'd3; req_use1 = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_op_valid", 32'(op_valid), 32'd1);
         chk("bp_op_a", 32'(op_a), 32'h111);
         chk("bp_op_b", 32'(op_b), 32'h222);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_enr0", 32'(ENR0), 32'd0);
         chk("bp_enr1", 32'(ENR1), 32'd0);
         step();
      end
      op_ready = 1'b1;
      #1;
      chk("bp_b2b_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0; op_ready = 1'b0;
      chk("bp_b2b_op_valid_low", 32'(op_valid), 32'd0);
      chk("bp_b2b_enr0", 32'(ENR0), 32'd1);
      chk("bp_b2b_rda1", 32'(RDA1), 32'd3);
      step();
      chk("bp_b2b_op_valid", 32'(op_valid), 32'd1);
      chk("bp_b2b_op_a", 32'(op_a), 32'h0AB);
      chk("bp_b2b_op_b", 32'(op_b), 32'h3FF);
      op_ready = 1'b1;
      step();
      op_ready = 1'b0;

      // Reset during HOLD with a write-back that must be blocked.
      req_valid = 1'b1; req_rs0 = 2'd2; req_rs1 = 2'd3; req_use1 = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      chk("mr_hold_op_a", 32'(op_a), 32'h222);
      Rstb = 1'b0; wb_valid = 1'b1; wb_addr = 2'd1; wb_data = 10'h3C3;
      #1;
      chk("mr_enw", 32'(ENW), 32'd0);
      chk("mr_wb_ready", 32'(wb_ready), 32'd0);
      chk("mr_req_ready", 32'(req_ready), 32'd0);
      step();
      chk("mr_op_valid", 32'(op_valid), 32'd0);
      chk("mr_op_a", 32'(op_a), 32'd0);
      chk("mr_op_b", 32'(op_b), 32'd0);
      Rstb = 1'b1; wb_valid = 1'b0;
      #1;
      chk("mr_req_ready_after", 32'(req_ready), 32'd1);
      do_fetch('{2'd1, 2'd2, 1'b1, 1'b0, 2'd0, 10'h000, 10'h111, 10'h222});

      // Randomized run against a transaction model.
      pend = 1'b0; have = 1'b0; pu = 1'b0; p0 = 2'd0; p1 = 2'd0; ea = 10'd0; eb = 10'd0;
      for (int i = 0; i < 400; i++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_rs0   = 2'($urandom);
         req_rs1   = 2'($urandom);
         req_use1  = 1'($urandom);
         op_ready  = 1'($urandom);
         wb_valid  = 1'($urandom);
         wb_addr   = 2'($urandom);
         wb_data   = 10'($urandom);
         #1;
         exp_rdy = !pend && (!have || op_ready);
         chk("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("rnd_enr0", 32'(ENR0), 32'(pend));
         chk("rnd_enr1", 32'(ENR1), 32'(pend && pu));
         chk("rnd_rda0", 32'(RDA0), pend ? 32'(p0) : 32'd0);
         chk("rnd_rda1", 32'(RDA1), pend ? 32'(p1) : 32'd0);
         chk("rnd_enw", 32'(ENW), 32'(wb_valid));
         chk("rnd_wra", 32'(WRA), 32'(wb_addr));
         chk("rnd_d", 32'(D), 32'(wb_data));
         chk("rnd_op_valid", 32'(op_valid), 32'(have));
         if (have) begin
            chk("rnd_op_a", 32'(op_a), 32'(ea));
            chk("rnd_op_b", 32'(op_b), 32'(eb));
         end
         if (pend) begin
            ea = (wb_valid && wb_addr == p0) ? wb_data : mdl[p0];
            eb = !pu ? 10'd0 : ((wb_valid && wb_addr == p1) ? wb_data : mdl[p1]);
            have = 1'b1;
            pend = 1'b0;
         end else if (have && op_ready) begin
            have = 1'b0;
         end
         if (exp_rdy && req_valid) begin
            pend = 1'b1; p0 = req_rs0; p1 = req_rs1; pu = req_use1;
         end
         step();
      end
      req_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b1;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
